// File: rtl/gate_op_sequencer.sv
// gate_op_sequencer: latches an operand pair, steps the decoder through AND/OR/XOR/NAND and hands each mux result downstream
// Ports: clk/rst_n clock and async active-low reset; start/a_in/b_in request and operands;
// a/b/dec_enable/dec_selector drive the gate+decoder; mux_out is the sampled mux result;
// result/result_sel/result_valid/result_ready form the downstream handshake; busy/done report sequence status.
module gate_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             dec_enable,
  output logic [1:0]       dec_selector,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       result_sel,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, FINISH} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      a            <= '0;
      b            <= '0;
      dec_enable   <= 1'b0;
      dec_selector <= 2'b00;
      result       <= '0;
      result_sel   <= 2'b00;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          a            <= a_in;
          b            <= b_in;
          dec_enable   <= 1'b1;
          dec_selector <= 2'b00;
          r_cnt        <= 4'(SETTLE_CYCLES);
          busy         <= 1'b1;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          // the edge that sees a count of 1 is the last one of the settle window
          if (r_cnt <= 4'd1) begin
            result       <= mux_out;
            result_sel   <= dec_selector;
            result_valid <= 1'b1;
            r_state      <= PRESENT;
          end
        end
        PRESENT: if (result_ready) begin
          result_valid <= 1'b0;
          if (dec_selector == 2'b11) begin
            done    <= 1'b1;
            r_state <= FINISH;
          end else begin
            dec_selector <= dec_selector + 2'd1;
            r_cnt        <= 4'(SETTLE_CYCLES);
            r_state      <= SETTLE;
          end
        end
        FINISH: begin
          dec_enable   <= 1'b0;
          dec_selector <= 2'b00;
          busy         <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_op_sequencer.sv
// tb_gate_op_sequencer: directed checks of the operation sequencer with a gate+mux model attached
module tb_gate_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       start, ready, glitch, start3, ready3;
  logic [3:0] a_in, b_in, a, b, mux_out, result;
  logic [3:0] a3, b3, mux3, res3;
  logic [1:0] dsel, rsel, dsel3, rsel3;
  logic       en, valid, busy, done, en3, valid3, busy3, done3;
  int checks = 0, fails = 0, done_cnt = 0;
  function automatic logic [3:0] gate_f(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y);
    return s == 2'd0 ? x & y : s == 2'd1 ? x | y : s == 2'd2 ? x ^ y : ~(x & y);
  endfunction
  assign mux_out = gate_f(dsel, a, b);
  assign mux3    = glitch ? ~gate_f(dsel3, a3, b3) : gate_f(dsel3, a3, b3);
  gate_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .a(a), .b(b),
    .dec_enable(en), .dec_selector(dsel), .mux_out(mux_out), .result(result), .result_sel(rsel),
    .result_valid(valid), .result_ready(ready), .busy(busy), .done(done));
  gate_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a_in), .b_in(b_in), .a(a3), .b(b3),
    .dec_enable(en3), .dec_selector(dsel3), .mux_out(mux3), .result(res3), .result_sel(rsel3),
    .result_valid(valid3), .result_ready(ready3), .busy(busy3), .done(done3));
  always @(negedge clk) if (done) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // exp packs the four expected results, selector 00 in the low nibble
  task automatic run(input logic [3:0] ai, input logic [3:0] bi, input logic [15:0] exp,
                     input int stall_sel, input int busy_sel);
    int lat;
    logic [3:0] e;
    done_cnt = 0;
    a_in = ai; b_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk("busy_run", busy, 1);
    for (int k = 0; k < 4; k++) begin
      e = exp[k*4 +: 4];
      while (!valid && lat < 20) begin tick(); lat++; end
      chk("latency", lat, 2);
      chk("result_sel", rsel, k);
      chk("result", result, e);
      if (k == stall_sel) begin
        ready = 1'b0;
        repeat (5) tick();
        chk("stall_valid", valid, 1);
        chk("stall_result", result, e);
        chk("stall_rsel", rsel, k);
        chk("stall_dsel", dsel, k);
        ready = 1'b1;
      end
      if (k == busy_sel) begin a_in = 4'hF; b_in = 4'hF; start = 1'b1; end
      tick();
      start = 1'b0;
      lat = 1;
      if (k == busy_sel) chk("busy_start_a", a, ai);
    end
    chk("done_pulse", done, 1);
    tick();
    chk("done_clear", done, 0);
    chk("busy_end", busy, 0);
    chk("en_end", en, 0);
    chk("dsel_end", dsel, 0);
    chk("a_kept", a, ai);
    chk("done_count", done_cnt, 1);
  endtask
  initial begin
    int n;
    start = 0; ready = 1; glitch = 0; start3 = 0; ready3 = 1; a_in = 0; b_in = 0;
    repeat (3) begin start = ~start; a_in = a_in + 4'd3; tick(); end
    start = 0;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_en", en, 0);
    chk("rst_dsel", dsel, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_a", a, 0);
    run(4'b1001, 4'b0001, 16'b1110_1000_1001_0001, -1, -1);
    run(4'b1001, 4'b0001, 16'b1110_1000_1001_0001, 1, 2);
    done_cnt = 0;
    a_in = 4'b1001; b_in = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(valid && rsel == 2'd1) && n < 20) begin tick(); n++; end
    chk("mid_reach", valid && rsel == 2'd1, 1);
    tick();
    chk("mid_dsel", dsel, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", a, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_dsel", dsel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mid_no_valid", valid, 0);
    chk("mid_no_done", done_cnt, 0);
    run(4'b0011, 4'b0101, 16'b1110_0110_0111_0001, -1, -1);
    a_in = 4'b1001; b_in = 4'b0001; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    glitch = 1'b1;
    tick();
    chk("s3_valid_c2", valid3, 0);
    tick();
    chk("s3_valid_c3", valid3, 0);
    glitch = 1'b0;
    tick();
    chk("s3_valid_c4", valid3, 1);
    chk("s3_result", res3, 4'b0001);
    chk("s3_rsel", rsel3, 0);
    n = 0;
    while (!done3 && n < 100) begin tick(); n++; end
    chk("s3_done", done3, 1);
    chk("s3_last_result", res3, 4'b1110);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
